// File: rtl/regs_xbar_pkg.sv
// Shared decode constants, FSM state type and byte-strobe merge helper for regs_xbar.
package regs_xbar_pkg;

    // Region field inside the ARM byte address
    localparam int REGION_MSB = 23;
    localparam int REGION_LSB = 20;

    // Read data returned with every error response
    localparam logic [31:0] ERRDATA = 32'hFFFF_FFFF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Replace only the bytes whose strobe bit is set
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/regs_timeout.sv
// Saturating wait counter: cleared by i_load, counts while i_en, flags expiry on the
// cycle whose clock edge brings the count up to LIMIT. LIMIT = 0 never expires.
module regs_timeout #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_load,
    input  logic i_en,
    output logic o_expired
);

    localparam int            CW  = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_cnt;

    // Counter: load clears, enable increments, holds at LIMIT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    generate
        if (LIMIT == 0) begin : g_never
            logic w_unused_cnt;
            assign w_unused_cnt = ^{r_cnt, i_en};
            assign o_expired    = 1'b0;
        end else begin : g_limit
            localparam logic [CW-1:0] LIM_M1 = CW'(LIMIT - 1);
            assign o_expired = i_en && (r_cnt >= LIM_M1);
        end
    endgenerate

endmodule

// File: rtl/regs_xbar.sv
// ARM register crossbar: local register file in region 0, request/ack channels in
// regions 1..NCH, with byte-strobe writes, wait timeout and error responses.
module regs_xbar
    import regs_xbar_pkg::*;
#(
    parameter int                   NREGS   = 16,
    parameter int                   NCH     = 2,
    parameter int                   ADDRW   = 20,
    parameter int                   TIMEOUT = 1023,
    parameter logic [NREGS*32-1:0]  RSTVAL  = '0
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [31:0]             armaddr,
    input  logic [31:0]             armwdata,
    input  logic [3:0]              armwstrb,
    input  logic                    armwr,
    input  logic                    armreq,
    output logic                    armack,
    output logic                    armerr,
    output logic [31:0]             armrdata,
    output logic [NREGS*32-1:0]     regq,
    output logic [NREGS-1:0]        regwr,
    output logic [NCH*ADDRW-1:0]    chaddr,
    output logic [NCH*32-1:0]       chwdata,
    output logic [NCH*4-1:0]        chwstrb,
    output logic [NCH-1:0]          chwr,
    output logic [NCH-1:0]          chreq,
    input  logic [NCH-1:0]          chack,
    input  logic [NCH-1:0]          cherr,
    input  logic [NCH*32-1:0]       chrdata
);

    localparam int          IDXW    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int          CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [31:0] NREGS_U = NREGS;
    localparam logic [31:0] NCH_U   = NCH;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_armreq0;
    logic              r_armack;
    logic              r_armerr;
    logic [31:0]       r_armrdata;
    logic [CHW-1:0]    r_sel;
    logic [31:0]       r_regs [NREGS];
    logic              r_regwr [NREGS];
    logic [ADDRW-1:0]  r_chaddr [NCH];
    logic [31:0]       r_chwdata [NCH];
    logic [3:0]        r_chwstrb [NCH];
    logic              r_chwr [NCH];
    logic              r_chreq [NCH];

    logic              w_edge;
    logic [3:0]        w_region;
    logic [17:0]       w_index;
    logic [IDXW-1:0]   w_word;
    logic              w_local_hit;
    logic              w_ch_hit;
    logic [3:0]        w_ch_idx;
    logic [31:0]       w_local_rd;
    logic              w_expired;
    logic              w_wait;
    logic              w_ack_next;
    logic              w_err_next;
    logic [31:0]       w_rdata_next;
    logic              w_local_wr;
    logic              w_ch_start;
    logic              w_ch_done;
    logic              w_unused_addr;

    assign w_edge        = armreq & ~r_armreq0;
    assign w_region      = armaddr[REGION_MSB:REGION_LSB];
    assign w_index       = armaddr[19:2];
    assign w_word        = w_index[IDXW-1:0];
    assign w_local_hit   = (w_region == 4'd0) && ({14'd0, w_index} < NREGS_U);
    assign w_ch_hit      = (w_region != 4'd0) && ({28'd0, w_region} <= NCH_U);
    assign w_ch_idx      = w_region - 4'd1;
    assign w_local_rd    = r_regs[w_word];
    assign w_wait        = (r_state == ST_WAIT);
    assign w_unused_addr = ^{armaddr[31:24], armaddr[1:0]};

    regs_timeout #(
        .LIMIT      (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_ch_start),
        .i_en       (w_wait),
        .o_expired  (w_expired)
    );

    // Next-state and response decode; ack/err/rdata are registered below
    always_comb begin
        w_state_next = r_state;
        w_ack_next   = 1'b0;
        w_err_next   = r_armerr;
        w_rdata_next = r_armrdata;
        w_local_wr   = 1'b0;
        w_ch_start   = 1'b0;
        w_ch_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    if (w_local_hit) begin
                        w_ack_next = 1'b1;
                        w_err_next = 1'b0;
                        if (armwr) begin
                            w_local_wr = 1'b1;
                        end else begin
                            w_rdata_next = w_local_rd;
                        end
                    end else if (w_ch_hit) begin
                        w_ch_start   = 1'b1;
                        w_state_next = ST_WAIT;
                    end else begin
                        w_ack_next   = 1'b1;
                        w_err_next   = 1'b1;
                        w_rdata_next = ERRDATA;
                    end
                end
            end
            ST_WAIT: begin
                // A real ack beats a coincident timeout
                if (chack[r_sel]) begin
                    w_ack_next   = 1'b1;
                    w_err_next   = cherr[r_sel];
                    w_rdata_next = chrdata[32*r_sel +: 32];
                    w_ch_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_expired) begin
                    w_ack_next   = 1'b1;
                    w_err_next   = 1'b1;
                    w_rdata_next = ERRDATA;
                    w_ch_done    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, request-edge history, response registers and selected channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_armreq0  <= 1'b1;
            r_armack   <= 1'b0;
            r_armerr   <= 1'b0;
            r_armrdata <= '0;
            r_sel      <= '0;
        end else begin
            r_state    <= w_state_next;
            r_armreq0  <= armreq;
            r_armack   <= w_ack_next;
            r_armerr   <= w_err_next;
            r_armrdata <= w_rdata_next;
            if (w_ch_start) begin
                r_sel <= w_ch_idx[CHW-1:0];
            end
        end
    end

    assign armack   = r_armack;
    assign armerr   = r_armerr;
    assign armrdata = r_armrdata;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            // Local register with byte-strobe merge and one-cycle write pulse
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_regs[gi]  <= RSTVAL[32*gi +: 32];
                    r_regwr[gi] <= 1'b0;
                end else begin
                    r_regwr[gi] <= 1'b0;
                    if (w_local_wr && (w_word == IDXW'(gi)) && (armwstrb != 4'd0)) begin
                        r_regs[gi]  <= strb_merge(r_regs[gi], armwdata, armwstrb);
                        r_regwr[gi] <= 1'b1;
                    end
                end
            end
            assign regq[32*gi +: 32] = r_regs[gi];
            assign regwr[gi]         = r_regwr[gi];
        end

        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // Channel request fields latched on start; request held until done
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_chaddr[gi]  <= '0;
                    r_chwdata[gi] <= '0;
                    r_chwstrb[gi] <= '0;
                    r_chwr[gi]    <= 1'b0;
                    r_chreq[gi]   <= 1'b0;
                end else if (w_ch_start && (w_ch_idx == 4'(gi))) begin
                    r_chaddr[gi]  <= armaddr[ADDRW-1:0];
                    r_chwdata[gi] <= armwdata;
                    r_chwstrb[gi] <= armwstrb;
                    r_chwr[gi]    <= armwr;
                    r_chreq[gi]   <= 1'b1;
                end else if (w_ch_done) begin
                    r_chreq[gi]   <= 1'b0;
                end
            end
            assign chaddr[ADDRW*gi +: ADDRW] = r_chaddr[gi];
            assign chwdata[32*gi +: 32]      = r_chwdata[gi];
            assign chwstrb[4*gi +: 4]        = r_chwstrb[gi];
            assign chwr[gi]                  = r_chwr[gi];
            assign chreq[gi]                 = r_chreq[gi];
        end
    endgenerate

endmodule

// File: tb/tb_regs_xbar.sv
// Directed bench for regs_xbar: table of local/error accesses plus hand sequences
// for channel handshakes, timeout, dropped edges and reset mid-access.
module tb_regs_xbar;

    localparam int           NREGS   = 16;
    localparam int           NCH     = 2;
    localparam int           ADDRW   = 20;
    localparam int           TIMEOUT = 8;
    localparam logic [511:0] RST_IMG = {384'h0, 32'h1234_5678, 96'h0};

    logic                 clk;
    logic                 rstn;
    logic [31:0]          armaddr;
    logic [31:0]          armwdata;
    logic [3:0]           armwstrb;
    logic                 armwr;
    logic                 armreq;
    logic                 armack;
    logic                 armerr;
    logic [31:0]          armrdata;
    logic [NREGS*32-1:0]  regq;
    logic [NREGS-1:0]     regwr;
    logic [NCH*ADDRW-1:0] chaddr;
    logic [NCH*32-1:0]    chwdata;
    logic [NCH*4-1:0]     chwstrb;
    logic [NCH-1:0]       chwr;
    logic [NCH-1:0]       chreq;
    logic [NCH-1:0]       chack;
    logic [NCH-1:0]       cherr;
    logic [NCH*32-1:0]    chrdata;

    int n_checks = 0;
    int n_fail   = 0;

    regs_xbar #(
        .NREGS    (NREGS),
        .NCH      (NCH),
        .ADDRW    (ADDRW),
        .TIMEOUT  (TIMEOUT),
        .RSTVAL   (RST_IMG)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .armaddr  (armaddr),
        .armwdata (armwdata),
        .armwstrb (armwstrb),
        .armwr    (armwr),
        .armreq   (armreq),
        .armack   (armack),
        .armerr   (armerr),
        .armrdata (armrdata),
        .regq     (regq),
        .regwr    (regwr),
        .chaddr   (chaddr),
        .chwdata  (chwdata),
        .chwstrb  (chwstrb),
        .chwr     (chwr),
        .chreq    (chreq),
        .chack    (chack),
        .cherr    (cherr),
        .chrdata  (chrdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        wr;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [15:0] exp_regwr;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w);
        armaddr  = a;
        armwdata = d;
        armwstrb = s;
        armwr    = w;
        armreq   = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp_img;
        int           hc;
        int           acks;

        //                addr          wdata         strb     wr    err   chk   exp_rd        regwr
        vecs[0]  = '{32'h0000_0004, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 1'b0, 32'h0,         16'h0002};
        vecs[1]  = '{32'h0000_0004, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b1, 32'h00BB_00DD, 16'h0000};
        vecs[2]  = '{32'h0000_000C, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 16'h0000};
        vecs[3]  = '{32'h0000_000C, 32'hFFEE_DDCC, 4'b1010, 1'b1, 1'b0, 1'b0, 32'h0,         16'h0008};
        vecs[4]  = '{32'h0000_000C, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b1, 32'hFF34_DD78, 16'h0000};
        vecs[5]  = '{32'h0000_003C, 32'hCAFE_F00D, 4'b1111, 1'b1, 1'b0, 1'b0, 32'h0,         16'h8000};
        vecs[6]  = '{32'h0000_003C, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, 16'h0000};
        vecs[7]  = '{32'h0000_0008, 32'h1111_1111, 4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,         16'h0000};
        vecs[8]  = '{32'h0000_0008, 32'h0,         4'b0000, 1'b0, 1'b0, 1'b1, 32'h0,         16'h0000};
        vecs[9]  = '{32'h0000_0040, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0000};
        vecs[10] = '{32'h00F0_0000, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0000};
        vecs[11] = '{32'h0030_0000, 32'h0,         4'b0000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0000};
        vecs[12] = '{32'h0000_0044, 32'h5555_5555, 4'b1111, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 16'h0000};

        rstn     = 1'b0;
        armaddr  = '0;
        armwdata = '0;
        armwstrb = '0;
        armwr    = 1'b0;
        armreq   = 1'b1;
        chack    = '0;
        cherr    = '0;
        chrdata  = '0;

        // Reset values, then a request held high across reset release is ignored
        repeat (3) tick();
        check("rst armack", armack, 1'b0);
        check("rst armrdata", armrdata, 32'h0);
        check("rst chreq", chreq, 2'b00);
        check("rst chaddr", chaddr, 40'h0);
        check("rst regq", regq, RST_IMG);
        rstn = 1'b1;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            acks += int'(armack) + int'(chreq != 0);
        end
        check("held req after reset", acks, 0);
        armreq = 1'b0;
        tick();

        // Table of local and decode-error accesses, each acked one cycle after the edge
        for (int i = 0; i < NVEC; i++) begin
            set_req(vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].wr);
            tick();
            check($sformatf("v%0d ack", i), armack, 1'b1);
            check($sformatf("v%0d err", i), armerr, vecs[i].exp_err);
            if (vecs[i].chk_rd) check($sformatf("v%0d rdata", i), armrdata, vecs[i].exp_rd);
            check($sformatf("v%0d regwr", i), regwr, vecs[i].exp_regwr);
            armreq = 1'b0;
            tick();
            check($sformatf("v%0d ack low", i), armack, 1'b0);
            check($sformatf("v%0d regwr low", i), regwr, 16'h0);
            $display("vec %0d addr=%h wr=%0d ack err=%0d rdata=%h", i, vecs[i].addr, vecs[i].wr, armerr, armrdata);
        end
        exp_img = RST_IMG;
        exp_img[32*1 +: 32]  = 32'h00BB_00DD;
        exp_img[32*3 +: 32]  = 32'hFF34_DD78;
        exp_img[32*15 +: 32] = 32'hCAFE_F00D;
        check("regq image", regq, exp_img);

        // Channel 0 read: stray ack on channel 1 ignored, real ack after 5 request cycles
        set_req(32'h0010_0010, 32'h0, 4'h0, 1'b0);
        tick();
        check("ch0 rd chreq", chreq, 2'b01);
        check("ch0 rd chaddr", chaddr[19:0], 20'h00010);
        check("ch0 rd chwr", chwr, 2'b00);
        armreq = 1'b0;
        hc = 1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) chack = 2'b10;
            tick();
            chack = 2'b00;
            hc += int'(chreq == 2'b01);
            acks += int'(armack);
        end
        chack = 2'b01;
        chrdata[31:0] = 32'h0000_0012;
        tick();
        chack = 2'b00;
        check("ch0 rd chreq cycles", hc, 5);
        check("ch0 rd early acks", acks, 0);
        check("ch0 rd chreq drop", chreq, 2'b00);
        check("ch0 rd ack", armack, 1'b1);
        check("ch0 rd err", armerr, 1'b0);
        check("ch0 rd rdata", armrdata, 32'h12);
        $display("ch0 read chaddr=%h ack rdata=%h", chaddr[19:0], armrdata);
        tick();
        check("ch0 rd ack low", armack, 1'b0);

        // Channel 0 write returning an error
        set_req(32'h001A_BCD4, 32'h600D_F00D, 4'b0011, 1'b1);
        tick();
        check("ch0 wr chaddr", chaddr[19:0], 20'hABCD4);
        check("ch0 wr chwdata", chwdata[31:0], 32'h600D_F00D);
        check("ch0 wr chwstrb", chwstrb[3:0], 4'b0011);
        check("ch0 wr chwr", chwr, 2'b01);
        check("ch1 untouched", chaddr[39:20], 20'h0);
        armreq = 1'b0;
        chack = 2'b01;
        cherr = 2'b01;
        chrdata[31:0] = 32'h0000_0077;
        tick();
        chack = 2'b00;
        cherr = 2'b00;
        check("ch0 wr ack", armack, 1'b1);
        check("ch0 wr err", armerr, 1'b1);
        check("ch0 wr rdata", armrdata, 32'h77);
        $display("ch0 write ack err=%0d rdata=%h", armerr, armrdata);
        tick();

        // Channel 1 timeout, then a late ack is ignored
        set_req(32'h0020_0020, 32'h0, 4'h0, 1'b0);
        tick();
        check("ch1 to chreq", chreq, 2'b10);
        check("ch1 to chaddr", chaddr[39:20], 20'h00020);
        check("ch0 chaddr kept", chaddr[19:0], 20'hABCD4);
        armreq = 1'b0;
        hc = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (chreq[1]) hc++;
            else break;
        end
        check("ch1 to chreq cycles", hc, TIMEOUT);
        check("ch1 to ack", armack, 1'b1);
        check("ch1 to err", armerr, 1'b1);
        check("ch1 to rdata", armrdata, 32'hFFFF_FFFF);
        $display("ch1 timeout after %0d cycles err=%0d", hc, armerr);
        tick();
        check("ch1 to ack low", armack, 1'b0);
        chack = 2'b10;
        chrdata[63:32] = 32'h0BAD_0BAD;
        acks = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chack = 2'b00;
            acks += int'(armack);
        end
        check("late ack ignored", acks, 0);
        check("late ack rdata held", armrdata, 32'hFFFF_FFFF);

        // Edge during WAIT is dropped; local write 2 cycles after the ack is normal
        set_req(32'h0010_0000, 32'h0, 4'h0, 1'b0);
        tick();
        armreq = 1'b0;
        tick();
        set_req(32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 1'b1);
        tick();
        check("wait edge no ack", armack, 1'b0);
        check("wait edge no regwr", regwr, 16'h0);
        armreq = 1'b0;
        tick();
        chack = 2'b01;
        chrdata[31:0] = 32'h0000_005A;
        tick();
        chack = 2'b00;
        check("wait seq ack", armack, 1'b1);
        check("wait seq rdata", armrdata, 32'h5A);
        tick();
        check("wait seq single ack", armack, 1'b0);
        set_req(32'h0000_0010, 32'h0000_0055, 4'b1111, 1'b1);
        tick();
        check("post ack wr ack", armack, 1'b1);
        check("post ack wr regwr", regwr, 16'h0010);
        armreq = 1'b0;
        tick();
        set_req(32'h0000_0000, 32'h0, 4'h0, 1'b0);
        tick();
        check("dropped wr not applied", armrdata, 32'h0);
        armreq = 1'b0;
        tick();
        $display("wait-edge sequence reg4=%h reg0=%h", regq[32*4 +: 32], regq[31:0]);

        // Reset during WAIT abandons the access; request held across release is ignored
        set_req(32'h0010_0000, 32'h0, 4'h0, 1'b0);
        tick();
        check("mid rst chreq before", chreq, 2'b01);
        rstn = 1'b0;
        #2;
        check("mid rst chreq", chreq, 2'b00);
        check("mid rst armack", armack, 1'b0);
        check("mid rst regq", regq, RST_IMG);
        tick();
        tick();
        rstn = 1'b1;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            acks += int'(armack) + int'(chreq != 0);
        end
        check("mid rst held req", acks, 0);
        armreq = 1'b0;
        tick();
        set_req(32'h0000_000C, 32'h0, 4'h0, 1'b0);
        tick();
        check("post rst rd ack", armack, 1'b1);
        check("post rst rd rdata", armrdata, 32'h1234_5678);
        armreq = 1'b0;
        tick();
        $display("reset mid-access done rdata=%h", armrdata);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
